// File: rtl/fsm_rx_cmd_parser.sv
// Command dispatcher: pops FWFT command/data FIFOs and pulses one registered lane per command.
// Optional RXCMD_BROADCAST_EN: an all-ones select drives every lane at once.

module fsm_rx_cmd_parser_lane #(
  parameter int AW = 5,
  parameter int CW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd_hit,
  input  logic          i_wr_hit,
  input  logic [AW-1:0] i_addr,
  input  logic [CW-1:0] i_cmd,
  input  logic [DW-1:0] i_data,
  output logic          o_rd_vld,
  output logic          o_wr_vld,
  output logic [AW-1:0] o_addr,
  output logic [CW-1:0] o_cmd,
  output logic [DW-1:0] o_data
);
  logic          r_rd_vld;
  logic          r_wr_vld;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cmd;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_vld <= 1'b0;
      r_wr_vld <= 1'b0;
      r_addr   <= '0;
      r_cmd    <= '0;
      r_data   <= '0;
    end else begin
      r_rd_vld <= i_rd_hit;
      r_wr_vld <= i_wr_hit;
      if (i_rd_hit || i_wr_hit) begin
        r_addr <= i_addr;
        r_cmd  <= i_cmd;
      end
      if (i_wr_hit) r_data <= i_data;
    end
  end

  assign o_rd_vld = r_rd_vld;
  assign o_wr_vld = r_wr_vld;
  assign o_addr   = r_addr;
  assign o_cmd    = r_cmd;
  assign o_data   = r_data;
endmodule

module fsm_rx_cmd_parser #(
  parameter int FIFO_DATA_WIDTH     = 32,
  parameter int FIFO_CMD_WIDTH      = 32,
  parameter int CMD_OUTPUT_WIDTH    = 5,
  parameter int MODULE_SELECT_WIDTH = 5,
  parameter int MODULES_CNT         = 13
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic [FIFO_CMD_WIDTH-1:0]                             i_cmd,
  input  logic                                                  i_cmd_valid,
  output logic                                                  o_cmd_rd_en,
  input  logic [FIFO_DATA_WIDTH-1:0]                            i_data,
  input  logic                                                  i_data_valid,
  output logic                                                  o_data_rd_en,
  output logic [MODULES_CNT-1:0]                                o_pipeline_read_valid,
  output logic [MODULES_CNT-1:0]                                o_pipeline_write_valid,
  output logic [MODULES_CNT-1:0][MODULE_SELECT_WIDTH-1:0]       o_pipeline_addr,
  output logic [MODULES_CNT-1:0][CMD_OUTPUT_WIDTH-1:0]          o_pipeline_cmd,
  output logic [MODULES_CNT-1:0][FIFO_DATA_WIDTH-1:0]           o_pipeline_data
);
  localparam int S    = MODULE_SELECT_WIDTH;
  localparam int C    = CMD_OUTPUT_WIDTH;
  localparam int USED = 1 + 2*S + C;

  typedef enum logic [1:0] {IDLE, WAIT_DATA, READ_OUT, WRITE_OUT} state_t;

  typedef struct packed {
    logic [S-1:0] addr;
    logic [C-1:0] cmd;
    logic [S-1:0] sel;
  } req_t;

  state_t                     r_state, w_state_nxt;
  req_t                       r_req;
  logic [FIFO_DATA_WIDTH-1:0] r_data;
  logic                       w_cmd_rd_en, w_data_rd_en;
  logic                       w_out_rd, w_out_wr, w_bcast;
  logic [MODULES_CNT-1:0]     w_hit;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cmd_rd_en  = 1'b0;
    w_data_rd_en = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_rd_en = i_cmd_valid;
        if (i_cmd_valid) w_state_nxt = i_cmd[0] ? WAIT_DATA : READ_OUT;
      end
      WAIT_DATA: begin
        w_data_rd_en = i_data_valid;
        if (i_data_valid) w_state_nxt = WRITE_OUT;
      end
      READ_OUT:  w_state_nxt = IDLE;
      WRITE_OUT: w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Gated by reset so a word is never consumed on the cycle that abandons a transaction.
  assign o_cmd_rd_en  = rst & w_cmd_rd_en;
  assign o_data_rd_en = rst & w_data_rd_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_req  <= '0;
      r_data <= '0;
    end else begin
      if (o_cmd_rd_en)
        r_req <= '{addr: i_cmd[2*S+C:S+C+1], cmd: i_cmd[S+C:S+1], sel: i_cmd[S:1]};
      if (o_data_rd_en) r_data <= i_data;
    end
  end

  generate
    if (FIFO_CMD_WIDTH > USED) begin : g_unused
      logic w_unused;
      assign w_unused = ^i_cmd[FIFO_CMD_WIDTH-1:USED];
    end
  endgenerate

  assign w_out_rd = (r_state == READ_OUT);
  assign w_out_wr = (r_state == WRITE_OUT);

`ifdef RXCMD_BROADCAST_EN
  assign w_bcast = &r_req.sel;
`else
  assign w_bcast = 1'b0;
`endif

  // Out-of-range selects match no lane, so the command drops silently.
  genvar i;
  generate
    for (i = 0; i < MODULES_CNT; i++) begin : g_lane
      assign w_hit[i] = (r_req.sel == S'(i)) | w_bcast;

      fsm_rx_cmd_parser_lane #(
        .AW(S), .CW(C), .DW(FIFO_DATA_WIDTH)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .i_rd_hit (w_out_rd & w_hit[i]),
        .i_wr_hit (w_out_wr & w_hit[i]),
        .i_addr   (r_req.addr),
        .i_cmd    (r_req.cmd),
        .i_data   (r_data),
        .o_rd_vld (o_pipeline_read_valid[i]),
        .o_wr_vld (o_pipeline_write_valid[i]),
        .o_addr   (o_pipeline_addr[i]),
        .o_cmd    (o_pipeline_cmd[i]),
        .o_data   (o_pipeline_data[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_fsm_rx_cmd_parser.sv
// Directed bench for fsm_rx_cmd_parser: queue-backed FWFT FIFOs, strobe event log, per-scenario checks.
module tb_fsm_rx_cmd_parser;
  localparam int DW = 32;
  localparam int FW = 32;
  localparam int C  = 5;
  localparam int S  = 5;
  localparam int M  = 13;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [FW-1:0] i_cmd = '0;
  logic          i_cmd_valid = 1'b0;
  logic          o_cmd_rd_en;
  logic [DW-1:0] i_data = '0;
  logic          i_data_valid = 1'b0;
  logic          o_data_rd_en;
  logic [M-1:0]  rdv, wrv;
  logic [M-1:0][S-1:0]  p_addr;
  logic [M-1:0][C-1:0]  p_cmd;
  logic [M-1:0][DW-1:0] p_data;

  fsm_rx_cmd_parser #(
    .FIFO_DATA_WIDTH(DW), .FIFO_CMD_WIDTH(FW), .CMD_OUTPUT_WIDTH(C),
    .MODULE_SELECT_WIDTH(S), .MODULES_CNT(M)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cmd(i_cmd), .i_cmd_valid(i_cmd_valid), .o_cmd_rd_en(o_cmd_rd_en),
    .i_data(i_data), .i_data_valid(i_data_valid), .o_data_rd_en(o_data_rd_en),
    .o_pipeline_read_valid(rdv), .o_pipeline_write_valid(wrv),
    .o_pipeline_addr(p_addr), .o_pipeline_cmd(p_cmd), .o_pipeline_data(p_data)
  );

  typedef struct {
    int           cyc;
    logic [M-1:0] rd;
    logic [M-1:0] wr;
    int           lane;
    int           nb;
    logic [S-1:0] addr;
    logic [C-1:0] cmd;
    logic [DW-1:0] data;
  } ev_t;

  ev_t         ev_q[$];
  logic [31:0] cmd_q[$];
  logic [31:0] data_q[$];
  int errors = 0, checks = 0;
  int cyc = 0, cpop_cyc = -1, dpop_cyc = -1, proto_err = 0;
  bit cpop, dpop;

  function automatic logic [31:0] mk(bit wr, int sel, int cm, int ad);
    return {16'b0, ad[4:0], cm[4:0], sel[4:0], wr};
  endfunction

  // FIFO model + strobe logger; inputs refresh at negedge+1, rd_en sampled at negedge+2.
  initial forever begin
    @(negedge clk); #1;
    i_cmd_valid  = (cmd_q.size() != 0);
    i_cmd        = i_cmd_valid ? cmd_q[0] : '0;
    i_data_valid = (data_q.size() != 0);
    i_data       = i_data_valid ? data_q[0] : '0;
    #1;
    cpop = o_cmd_rd_en && i_cmd_valid;
    dpop = o_data_rd_en && i_data_valid;
    if ((o_cmd_rd_en && !i_cmd_valid) || (o_data_rd_en && !i_data_valid)) proto_err++;
    @(posedge clk);
    cyc++;
    #1;
    if (cpop && cmd_q.size() != 0)  begin void'(cmd_q.pop_front());  cpop_cyc = cyc - 1; end
    if (dpop && data_q.size() != 0) begin void'(data_q.pop_front()); dpop_cyc = cyc - 1; end
    i_cmd_valid  = (cmd_q.size() != 0);
    i_cmd        = i_cmd_valid ? cmd_q[0] : '0;
    i_data_valid = (data_q.size() != 0);
    i_data       = i_data_valid ? data_q[0] : '0;
    #2;
    if ((rdv | wrv) != '0) begin
      ev_t e;
      logic [M-1:0] any;
      any    = rdv | wrv;
      e.cyc  = cyc;
      e.rd   = rdv;
      e.wr   = wrv;
      e.nb   = $countones(any);
      e.lane = 0;
      for (int i = M-1; i >= 0; i--) if (any[i]) e.lane = i;
      e.addr = p_addr[e.lane];
      e.cmd  = p_cmd[e.lane];
      e.data = p_data[e.lane];
      ev_q.push_back(e);
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    cmd_q.push_back(mk(0, 3, 5, 2));
    data_q.push_back(32'h1234);
    repeat (3) begin
      @(negedge clk); #2;
      checks++;
      if (o_cmd_rd_en !== 1'b0 || o_data_rd_en !== 1'b0 || rdv !== '0 || wrv !== '0 ||
          p_addr !== '0 || p_cmd !== '0 || p_data !== '0) begin
        errors++;
        $display("FAIL reset_hold: rd_en=%b/%b rdv=%h wrv=%h required all zero",
                 o_cmd_rd_en, o_data_rd_en, rdv, wrv);
      end
    end
    checks++;
    if (cmd_q.size() != 1 || data_q.size() != 1) begin
      errors++;
      $display("FAIL reset_no_pop: cmd_q=%0d data_q=%0d required 1/1", cmd_q.size(), data_q.size());
    end
    cmd_q.delete();
    data_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [M-1:0][S-1:0]  sa;
    logic [M-1:0][C-1:0]  sc;
    logic [M-1:0][DW-1:0] sd;
    int bad;
    sa = p_addr; sc = p_cmd; sd = p_data;
    ev_q.delete();
    cmd_q.push_back(mk(0, 3, 5, 2));
    for (int k = 0; k < 20 && ev_q.size() < 1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (ev_q.size() != 1) begin
      errors++;
      $display("FAIL read_count: strobes=%0d required 1", ev_q.size());
    end
    if (ev_q.size() >= 1) begin
      checks++;
      if (ev_q[0].rd !== 13'b0000000001000 || ev_q[0].wr !== '0) begin
        errors++;
        $display("FAIL read_strobe: rd=%b wr=%b required rd=0000000001000 wr=0", ev_q[0].rd, ev_q[0].wr);
      end
      checks++;
      if (ev_q[0].cmd !== 5'd5 || ev_q[0].addr !== 5'd2) begin
        errors++;
        $display("FAIL read_fields: cmd=%0d addr=%0d required 5/2", ev_q[0].cmd, ev_q[0].addr);
      end
      checks++;
      if (ev_q[0].cyc - cpop_cyc != 2) begin
        errors++;
        $display("FAIL read_latency: %0d required 2", ev_q[0].cyc - cpop_cyc);
      end
    end
    bad = 0;
    for (int i = 0; i < M; i++)
      if (i != 3 && (p_addr[i] !== sa[i] || p_cmd[i] !== sc[i] || p_data[i] !== sd[i])) bad++;
    if (p_data[3] !== sd[3]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL read_other_lanes: %0d changed required 0", bad);
    end
  endtask

  task automatic test_write_wait();
    ev_q.delete();
    cmd_q.push_back(mk(1, 7, 1, 4));
    repeat (10) @(negedge clk);
    checks++;
    if (cmd_q.size() != 0 || ev_q.size() != 0 || o_data_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL write_wait: cmd_q=%0d strobes=%0d data_rd_en=%b required 0/0/0",
               cmd_q.size(), ev_q.size(), o_data_rd_en);
    end
    data_q.push_back(32'h0000_00AB);
    for (int k = 0; k < 20 && ev_q.size() < 1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || data_q.size() != 0) begin
      errors++;
      $display("FAIL write_count: strobes=%0d data_q=%0d required 1/0", ev_q.size(), data_q.size());
    end
    if (ev_q.size() >= 1) begin
      checks++;
      if (ev_q[0].wr !== 13'b0000010000000 || ev_q[0].rd !== '0) begin
        errors++;
        $display("FAIL write_strobe: wr=%b rd=%b required wr=0000010000000 rd=0", ev_q[0].wr, ev_q[0].rd);
      end
      checks++;
      if (ev_q[0].data !== 32'hAB || ev_q[0].cmd !== 5'd1 || ev_q[0].addr !== 5'd4) begin
        errors++;
        $display("FAIL write_fields: data=%h cmd=%0d addr=%0d required ab/1/4",
                 ev_q[0].data, ev_q[0].cmd, ev_q[0].addr);
      end
      checks++;
      if (ev_q[0].cyc - dpop_cyc != 2) begin
        errors++;
        $display("FAIL write_latency: %0d required 2", ev_q[0].cyc - dpop_cyc);
      end
    end
  endtask

  task automatic test_streaming();
    int n, gap_bad, shown;
    ev_q.delete();
    for (int sel = 0; sel < M; sel++) begin
      for (int c = 0; c < 64; c++) cmd_q.push_back(mk(0, sel, c, c >> 5));
      for (int c = 0; c < 64; c++) begin
        cmd_q.push_back(mk(1, sel, c, c >> 5));
        data_q.push_back(c);
      end
    end
    for (int k = 0; k < 8000 && ev_q.size() < M*128; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (ev_q.size() != M*128) begin
      errors++;
      $display("FAIL stream_count: strobes=%0d required %0d", ev_q.size(), M*128);
    end
    n = (ev_q.size() < M*128) ? ev_q.size() : M*128;
    gap_bad = 0;
    shown = 0;
    for (int k = 0; k < n; k++) begin
      int sel, j, c;
      bit wr, ok;
      logic [M-1:0] oh;
      sel = k / 128;
      j   = k % 128;
      wr  = (j >= 64);
      c   = j % 64;
      oh  = '0;
      oh[sel] = 1'b1;
      ok = (ev_q[k].nb == 1) && (ev_q[k].cmd == c[4:0]) && (ev_q[k].addr == 5'(c >> 5));
      if (wr) ok = ok && (ev_q[k].wr == oh) && (ev_q[k].rd == '0) && (ev_q[k].data == 32'(c));
      else    ok = ok && (ev_q[k].rd == oh) && (ev_q[k].wr == '0);
      checks++;
      if (!ok) begin
        errors++;
        if (shown < 10)
          $display("FAIL stream_event %0d: rd=%b wr=%b cmd=%0d addr=%0d data=%h required lane %0d %s cmd=%0d addr=%0d",
                   k, ev_q[k].rd, ev_q[k].wr, ev_q[k].cmd, ev_q[k].addr, ev_q[k].data,
                   sel, wr ? "write" : "read", c, c >> 5);
        shown++;
      end
      if (!wr && j > 0 && ev_q[k].cyc - ev_q[k-1].cyc != 2) gap_bad++;
    end
    checks++;
    if (gap_bad != 0) begin
      errors++;
      $display("FAIL stream_throughput: %0d read gaps not equal 2 clk required 0", gap_bad);
    end
  endtask

  task automatic test_out_of_range();
    logic [M-1:0][S-1:0]  sa;
    logic [M-1:0][C-1:0]  sc;
    logic [M-1:0][DW-1:0] sd;
    int bad;
    sa = p_addr; sc = p_cmd; sd = p_data;
    ev_q.delete();
    cmd_q.push_back(mk(1, 13, 2, 3));
    data_q.push_back(32'h55);
    cmd_q.push_back(mk(0, 1, 9, 6));
    for (int k = 0; k < 30 && ev_q.size() < 1; k++) @(negedge clk);
    repeat (6) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || cmd_q.size() != 0 || data_q.size() != 0) begin
      errors++;
      $display("FAIL oor_drop: strobes=%0d cmd_q=%0d data_q=%0d required 1/0/0",
               ev_q.size(), cmd_q.size(), data_q.size());
    end
    if (ev_q.size() >= 1) begin
      checks++;
      if (ev_q[0].rd !== 13'b0000000000010 || ev_q[0].wr !== '0 ||
          ev_q[0].cmd !== 5'd9 || ev_q[0].addr !== 5'd6) begin
        errors++;
        $display("FAIL oor_next: rd=%b wr=%b cmd=%0d addr=%0d required rd=0000000000010 cmd=9 addr=6",
                 ev_q[0].rd, ev_q[0].wr, ev_q[0].cmd, ev_q[0].addr);
      end
    end
    bad = 0;
    for (int i = 0; i < M; i++)
      if (i != 1 && (p_addr[i] !== sa[i] || p_cmd[i] !== sc[i] || p_data[i] !== sd[i])) bad++;
    if (p_data[1] !== sd[1]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL oor_lanes: %0d changed required 0", bad);
    end

    sa = p_addr; sc = p_cmd; sd = p_data;
    ev_q.delete();
    cmd_q.push_back(mk(0, 31, 4, 4));
    repeat (10) @(negedge clk);
`ifdef RXCMD_BROADCAST_EN
    checks++;
    if (ev_q.size() != 1 || (ev_q.size() == 1 && (ev_q[0].rd !== '1 || ev_q[0].wr !== '0))) begin
      errors++;
      $display("FAIL bcast_strobe: strobes=%0d required one all-lane read", ev_q.size());
    end
    bad = 0;
    for (int i = 0; i < M; i++) if (p_addr[i] !== 5'd4 || p_cmd[i] !== 5'd4) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bcast_lanes: %0d lanes wrong required 0", bad);
    end
`else
    bad = 0;
    for (int i = 0; i < M; i++)
      if (p_addr[i] !== sa[i] || p_cmd[i] !== sc[i] || p_data[i] !== sd[i]) bad++;
    checks++;
    if (ev_q.size() != 0 || cmd_q.size() != 0 || bad != 0) begin
      errors++;
      $display("FAIL allones_drop: strobes=%0d cmd_q=%0d changed=%0d required 0/0/0",
               ev_q.size(), cmd_q.size(), bad);
    end
`endif
  endtask

  task automatic test_mid_reset();
    ev_q.delete();
    cmd_q.push_back(mk(1, 2, 7, 7));
    for (int k = 0; k < 10 && cmd_q.size() != 0; k++) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    data_q.push_back(32'hDEAD);
    #2;
    checks++;
    if (o_data_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst_rd_en: data_rd_en=%b required 0", o_data_rd_en);
    end
    @(negedge clk); #2;
    checks++;
    if (data_q.size() != 1 || rdv !== '0 || wrv !== '0 || p_addr !== '0 || p_cmd !== '0 || p_data !== '0) begin
      errors++;
      $display("FAIL midrst_state: data_q=%0d rdv=%h wrv=%h required 1 and outputs zero",
               data_q.size(), rdv, wrv);
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (data_q.size() != 1 || ev_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_idle: data_q=%0d strobes=%0d required 1/0", data_q.size(), ev_q.size());
    end
    cmd_q.push_back(mk(0, 4, 3, 1));
    for (int k = 0; k < 20 && ev_q.size() < 1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (ev_q.size() != 1 || data_q.size() != 1 ||
        (ev_q.size() == 1 && (ev_q[0].rd !== 13'b0000000010000 || ev_q[0].cmd !== 5'd3 || ev_q[0].addr !== 5'd1))) begin
      errors++;
      $display("FAIL midrst_recover: strobes=%0d data_q=%0d required one lane4 read, data kept",
               ev_q.size(), data_q.size());
    end
    data_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_streaming();
    test_out_of_range();
    test_mid_reset();
    checks++;
    if (proto_err != 0) begin
      errors++;
      $display("FAIL rd_en_protocol: %0d cycles with rd_en on empty FIFO required 0", proto_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
